// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
//   Shared constants and helpers for the multi-port register file:
//   default geometry, a constant-safe clog2, and the per-port slice helper
//   used to locate port i inside the flattened ra/rd buses.
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int NRD_MAX   = 4;

    // Address width for n entries. Never returns 0, so a 1-entry or
    // 2-entry file still gets a usable 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Low bit of port `port` inside a flattened bus of `w`-bit fields.
    function automatic int port_lo(input int port, input int w);
        return port * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//   Pending-load scoreboard. One bit per architectural register; a bit is
//   set when a load targeting that register issues and cleared when the
//   load-fill write port retires data into it.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset, clears every bit
//   i_set      in   load issued this cycle
//   i_set_addr in   destination register of the issued load
//   i_clr      in   load-fill write this cycle
//   i_clr_addr in   register written by the load fill
//   o_busy     out  current scoreboard, bit r = register r pending
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_set,
    input  logic [AW-1:0]    i_set_addr,
    input  logic             i_clr,
    input  logic [AW-1:0]    i_clr_addr,
    output logic [NREGS-1:0] o_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_next;

    // Clear first, then set: a new load issuing in the same cycle as the
    // previous fill of that register must leave the register pending.
    always_comb begin
        w_next = r_busy;
        if (i_clr) w_next[i_clr_addr] = 1'b0;
        if (i_set) w_next[i_set_addr] = 1'b1;
        if (ZERO_REG != 0) w_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_next;
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised integer register file: NRD asynchronous read ports, two
//   write ports (0 = ALU writeback, 1 = load fill), optional hardwired zero
//   register, optional write-first bypass, and a pending-load scoreboard
//   consulted by the hazard unit.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset (storage + scoreboard)
//   ra         in   read addresses, port i at [i*AW +: AW]
//   rd         out  read data, port i at [i*XLEN +: XLEN]
//   rd_busy    out  port i addresses a register with a load outstanding
//   we0/wa0/wd0 in  ALU writeback port
//   we1/wa1/wd1 in  load-fill port, wins over port 0 on address collision
//   busy_set   in   a load to busy_addr issues this cycle
//   busy_addr  in   destination register of that load
//   busy_vec   out  full scoreboard
// ---------------------------------------------------------------------------
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                busy_set,
    input  logic [AW-1:0]       busy_addr,
    output logic [NREGS-1:0]    busy_vec
);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_wr0;
    logic            w_wr1;

    // Writes to the zero register are simply never performed, so entry 0
    // keeps its reset value of 0 forever.
    assign w_wr0 = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign w_wr1 = we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Port 1 is written after port 0 so it wins on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) r_mem[k] <= '0;
        end else begin
            if (w_wr0) r_mem[wa0] <= wd0;
            if (w_wr1) r_mem[wa1] <= wd1;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: only the load-fill port retires a pending load.
    // ------------------------------------------------------------------
    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set      (busy_set),
        .i_set_addr (busy_addr),
        .i_clr      (we1),
        .i_clr_addr (wa1),
        .o_busy     (busy_vec)
    );

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    // Bypass is held off during reset so rd reads 0 even if a write strobe
    // happens to be high while the array is being cleared.
    logic w_byp_en;
    assign w_byp_en = (BYPASS != 0) && !rst;

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_hit0;
        logic            w_hit1;

        assign w_ra   = ra[port_lo(gi, AW) +: AW];
        assign w_hit1 = w_byp_en && we1 && (wa1 == w_ra);
        assign w_hit0 = w_byp_en && we0 && (wa0 == w_ra);

        // Priority mirrors the write ordering: zero reg, fill, ALU, array.
        always_comb begin
            if ((ZERO_REG != 0) && (w_ra == '0)) w_rd = '0;
            else if (w_hit1)                     w_rd = wd1;
            else if (w_hit0)                     w_rd = wd0;
            else                                 w_rd = r_mem[w_ra];
        end

        assign rd[port_lo(gi, XLEN) +: XLEN] = w_rd;

        // A fill arriving this cycle is forwarded, so the consumer need
        // not stall on it even though the busy bit clears only next cycle.
        assign rd_busy[gi] = busy_vec[w_ra] & ~w_hit1;
    end

endmodule
